blob_stats: RTL and testbench

Consumes the labeled pixel stream produced by the connected-components labeler: `label_in`, `hcount_in`, `vcount_in`, `valid_in`. Per frame, it accumulates a bounding box and an area for each tracked label. At end of frame it emits one record per non-empty label over a valid/ready handshake, then clears itself for the next frame. It sits between the labeler and the downstream object-selection/steering logic.

---
 rtl/blob_pkg.sv | 38 +++
 rtl/blob_accum_entry.sv | 75 +++++++
 rtl/blob_stats.sv | 185 ++++++++++++++++++
 tb/tb_blob_stats.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared types and constants for the per-frame blob statistics block.
package blob_pkg;

    // Frame-level controller states.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } blob_state_t;

    // The record carries a generous area field so any AREA_W fits without
    // changing the shared type; the top narrows it onto its output port.
    localparam int REC_AREA_W = 32;

    typedef struct packed {
        logic [15:0]           label;
        logic [10:0]           xmin;
        logic [10:0]           xmax;
        logic [9:0]            ymin;
        logic [9:0]            ymax;
        logic [REC_AREA_W-1:0] area;
    } blob_rec_t;

    // Cleared entry: empty area and an inverted box so the first pixel
    // overwrites both extremes.
    localparam logic [10:0] CLR_XMAX = 11'd0;
    localparam logic [9:0]  CLR_YMAX = 10'd0;

    function automatic logic [10:0] clr_xmin(input int hres);
        return 11'(hres - 1);
    endfunction

    function automatic logic [9:0] clr_ymin(input int vres);
        return 10'(vres - 1);
    endfunction

endpackage

// File: rtl/blob_accum_entry.sv
// One tracked label: bounding box and saturating area, updated by a
// single-cycle read-modify-write so back-to-back hits both count.
module blob_accum_entry
    import blob_pkg::*;
#(
    parameter int HRES   = 320,
    parameter int VRES   = 180,
    parameter int AREA_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              hit_in,
    input  logic              clear_in,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    output logic [10:0]       xmin_out,
    output logic [10:0]       xmax_out,
    output logic [9:0]        ymin_out,
    output logic [9:0]        ymax_out,
    output logic [AREA_W-1:0] area_out
);

    localparam logic [10:0] CLR_XMIN = clr_xmin(HRES);
    localparam logic [9:0]  CLR_YMIN = clr_ymin(VRES);

    logic [10:0]       xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]        ymin_q, ymin_d, ymax_q, ymax_d;
    logic [AREA_W-1:0] area_q, area_d;

    // Next entry value: clear wins over a hit; otherwise widen box and count.
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        area_d = area_q;
        if (clear_in) begin
            xmin_d = CLR_XMIN;
            xmax_d = CLR_XMAX;
            ymin_d = CLR_YMIN;
            ymax_d = CLR_YMAX;
            area_d = '0;
        end else if (hit_in) begin
            if (x_in < xmin_q) xmin_d = x_in;
            if (x_in > xmax_q) xmax_d = x_in;
            if (y_in < ymin_q) ymin_d = y_in;
            if (y_in > ymax_q) ymax_d = y_in;
            if (area_q != '1) area_d = area_q + AREA_W'(1);
        end
    end

    // Entry registers, reset to the cleared state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            xmin_q <= CLR_XMIN;
            xmax_q <= CLR_XMAX;
            ymin_q <= CLR_YMIN;
            ymax_q <= CLR_YMAX;
            area_q <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            area_q <= area_d;
        end
    end

    assign xmin_out = xmin_q;
    assign xmax_out = xmax_q;
    assign ymin_out = ymin_q;
    assign ymax_out = ymax_q;
    assign area_out = area_q;

endmodule

// File: rtl/blob_stats.sv
// Per-frame blob statistics: accumulates box/area per label during the
// frame, then scans the table and emits one record per non-empty label.
module blob_stats
    import blob_pkg::*;
#(
    parameter int HRES        = 320,
    parameter int VRES        = 180,
    parameter int MAX_TRACKED = 16,
    parameter int AREA_W      = $clog2(HRES * VRES + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [15:0]       label_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              valid_in,
    output logic              blob_valid_out,
    input  logic              blob_ready_in,
    output logic [15:0]       blob_label_out,
    output logic [10:0]       blob_xmin_out,
    output logic [10:0]       blob_xmax_out,
    output logic [9:0]        blob_ymin_out,
    output logic [9:0]        blob_ymax_out,
    output logic [AREA_W-1:0] blob_area_out,
    output logic              frame_done_out,
    output logic              overflow_out,
    output logic              dropped_out
);

    // Index must reach MAX_TRACKED+1 so the scan can step past the last entry.
    localparam int             IDX_W   = $clog2(MAX_TRACKED + 2);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_TRACKED);
    localparam logic [15:0]    MAX_LBL = 16'(MAX_TRACKED);
    localparam logic [10:0]    H_RES   = 11'(HRES);
    localparam logic [9:0]     V_RES   = 10'(VRES);
    localparam logic [10:0]    H_LAST  = 11'(HRES - 1);
    localparam logic [9:0]     V_LAST  = 10'(VRES - 1);

    blob_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;

    logic                  accum_px;
    logic                  clear_all;
    logic [MAX_TRACKED:1]  hit;
    logic [10:0]           xmin_a [1:MAX_TRACKED];
    logic [10:0]           xmax_a [1:MAX_TRACKED];
    logic [9:0]            ymin_a [1:MAX_TRACKED];
    logic [9:0]            ymax_a [1:MAX_TRACKED];
    logic [AREA_W-1:0]     area_a [1:MAX_TRACKED];

    logic [10:0]       xmin_sel, xmax_sel;
    logic [9:0]        ymin_sel, ymax_sel;
    logic [AREA_W-1:0] area_sel;
    blob_rec_t         rec;

    // Only in-frame, in-range pixels reach the table; label decode picks the entry.
    assign accum_px  = (state_q == ACCUM) && valid_in &&
                       (hcount_in < H_RES) && (vcount_in < V_RES);
    assign clear_all = (state_q == DONE);

    for (genvar g = 1; g <= MAX_TRACKED; g++) begin : g_entry
        assign hit[g] = accum_px && (label_in == 16'(g));

        blob_accum_entry #(
            .HRES   (HRES),
            .VRES   (VRES),
            .AREA_W (AREA_W)
        ) u_entry (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .hit_in   (hit[g]),
            .clear_in (clear_all),
            .x_in     (hcount_in),
            .y_in     (vcount_in),
            .xmin_out (xmin_a[g]),
            .xmax_out (xmax_a[g]),
            .ymin_out (ymin_a[g]),
            .ymax_out (ymax_a[g]),
            .area_out (area_a[g])
        );
    end

    // Select the entry under the scan index; out-of-range index reads as empty.
    always_comb begin
        xmin_sel = '0;
        xmax_sel = '0;
        ymin_sel = '0;
        ymax_sel = '0;
        area_sel = '0;
        for (int i = 1; i <= MAX_TRACKED; i++) begin
            if (idx_q == IDX_W'(i)) begin
                xmin_sel = xmin_a[i];
                xmax_sel = xmax_a[i];
                ymin_sel = ymin_a[i];
                ymax_sel = ymax_a[i];
                area_sel = area_a[i];
            end
        end
    end

    // Frame controller: next state, scan index and sticky frame flags.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        case (state_q)
            ACCUM: begin
                if (valid_in && (label_in > MAX_LBL)) ovf_d = 1'b1;
                if (valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST)) begin
                    state_d = SCAN;
                    idx_d   = IDX_W'(1);
                end
            end
            SCAN: begin
                if (valid_in) drop_d = 1'b1;
                if (idx_q > IDX_MAX) begin
                    state_d = DONE;
                end else if (area_sel == '0) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (valid_in) drop_d = 1'b1;
                if (blob_ready_in) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = (idx_q == IDX_MAX) ? DONE : SCAN;
                end
            end
            DONE: begin
                // Flags restart here; a pixel landing on this cycle already
                // belongs to the next frame's drop report.
                state_d = ACCUM;
                idx_d   = '0;
                ovf_d   = 1'b0;
                drop_d  = valid_in;
            end
            default: state_d = ACCUM;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Output record: driven only in EMIT so idle outputs read as zero.
    always_comb begin
        rec = '0;
        if (state_q == EMIT) begin
            rec.label = 16'(idx_q);
            rec.xmin  = xmin_sel;
            rec.xmax  = xmax_sel;
            rec.ymin  = ymin_sel;
            rec.ymax  = ymax_sel;
            rec.area  = REC_AREA_W'(area_sel);
        end
    end

    assign blob_valid_out = (state_q == EMIT);
    assign blob_label_out = rec.label;
    assign blob_xmin_out  = rec.xmin;
    assign blob_xmax_out  = rec.xmax;
    assign blob_ymin_out  = rec.ymin;
    assign blob_ymax_out  = rec.ymax;
    assign blob_area_out  = AREA_W'(rec.area);
    assign frame_done_out = (state_q == DONE);
    assign overflow_out   = (state_q == DONE) && ovf_q;
    assign dropped_out    = (state_q == DONE) && drop_q;

endmodule

// File: tb/tb_blob_stats.sv
// Scoreboard bench for blob_stats: stimulus pushes expected records from a
// table-based frame model; a negedge monitor pops and compares.
module tb_blob_stats;

    localparam int HRES = 320;
    localparam int VRES = 180;
    localparam int MAXT = 16;
    localparam int AW   = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [15:0]   label_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          valid_in;
    logic          blob_valid_out;
    logic          blob_ready_in;
    logic [15:0]   blob_label_out;
    logic [10:0]   blob_xmin_out, blob_xmax_out;
    logic [9:0]    blob_ymin_out, blob_ymax_out;
    logic [AW-1:0] blob_area_out;
    logic          frame_done_out, overflow_out, dropped_out;

    blob_stats #(.HRES(HRES), .VRES(VRES), .MAX_TRACKED(MAXT), .AREA_W(AW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .label_in       (label_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .valid_in       (valid_in),
        .blob_valid_out (blob_valid_out),
        .blob_ready_in  (blob_ready_in),
        .blob_label_out (blob_label_out),
        .blob_xmin_out  (blob_xmin_out),
        .blob_xmax_out  (blob_xmax_out),
        .blob_ymin_out  (blob_ymin_out),
        .blob_ymax_out  (blob_ymax_out),
        .blob_area_out  (blob_area_out),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out),
        .dropped_out    (dropped_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        v;
        logic [15:0] l;
        logic [10:0] x;
        logic [9:0]  y;
    } px_t;

    typedef struct {
        bit          done;
        logic [15:0] label;
        logic [10:0] xmin, xmax;
        logic [9:0]  ymin, ymax;
        logic [15:0] area;
        bit          ovf, drop;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    px_t  pxq[$];

    int m_area [MAXT+1];
    int m_xmin [MAXT+1];
    int m_xmax [MAXT+1];
    int m_ymin [MAXT+1];
    int m_ymax [MAXT+1];
    bit m_ovf;

    bit ready_rand = 0;
    bit force_low  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready generator
    initial begin
        blob_ready_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (force_low)       blob_ready_in = 1'b0;
            else if (ready_rand) blob_ready_in = 1'($urandom % 2);
            else                 blob_ready_in = 1'b1;
        end
    end

    // Monitor: record handshakes, hold stability and frame-done flags
    bit          stall_prev = 0;
    logic [79:0] held;
    always @(negedge clk_in) begin
        logic [79:0] cur;
        exp_t e;
        cur = {6'd0, blob_label_out, blob_xmin_out, blob_xmax_out,
               blob_ymin_out, blob_ymax_out, blob_area_out};
        if (!rst_n_in) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", blob_valid_out, 1);
                chk("hold_fields", cur, held);
            end
            stall_prev = 0;
            if (blob_valid_out) begin
                if (blob_ready_in) begin
                    if (q.size() == 0 || q[0].done) begin
                        total++; bad++;
                        $display("FAIL record: got unexpected label %0d expected none", blob_label_out);
                    end else begin
                        e = q.pop_front();
                        chk("record", cur, {6'd0, e.label, e.xmin, e.xmax, e.ymin, e.ymax, e.area});
                    end
                end else begin
                    stall_prev = 1;
                    held = cur;
                end
            end
            if (frame_done_out) begin
                if (q.size() == 0 || !q[0].done) begin
                    total++; bad++;
                    $display("FAIL frame_done: got early pulse expected record first (queue %0d)", q.size());
                end else begin
                    e = q.pop_front();
                    chk("overflow", overflow_out, e.ovf);
                    chk("dropped", dropped_out, e.drop);
                end
            end
        end
    end

    task automatic drive(input px_t p);
        @(posedge clk_in);
        #1;
        valid_in  = p.v;
        label_in  = p.l;
        hcount_in = p.x;
        vcount_in = p.y;
    endtask

    task automatic model(input px_t p);
        int l;
        if (!p.v) return;
        l = int'(p.l);
        if (l > MAXT) m_ovf = 1;
        else if (l != 0 && int'(p.x) < HRES && int'(p.y) < VRES) begin
            m_area[l]++;
            if (int'(p.x) < m_xmin[l]) m_xmin[l] = int'(p.x);
            if (int'(p.x) > m_xmax[l]) m_xmax[l] = int'(p.x);
            if (int'(p.y) < m_ymin[l]) m_ymin[l] = int'(p.y);
            if (int'(p.y) > m_ymax[l]) m_ymax[l] = int'(p.y);
        end
    endtask

    // Drives pxq then the end-of-frame pixel, pushes expectations, then
    // optional junk pixels; returns one cycle after the EOF pixel is sampled.
    task automatic run_frame(input logic [15:0] eof_l, input int junk);
        px_t  p;
        exp_t e;
        for (int l = 0; l <= MAXT; l++) begin
            m_area[l] = 0; m_xmin[l] = HRES - 1; m_xmax[l] = 0;
            m_ymin[l] = VRES - 1; m_ymax[l] = 0;
        end
        m_ovf = 0;
        foreach (pxq[k]) begin
            drive(pxq[k]);
            model(pxq[k]);
        end
        p = '{v: 1'b1, l: eof_l, x: 11'(HRES - 1), y: 10'(VRES - 1)};
        drive(p);
        model(p);
        for (int l = 1; l <= MAXT; l++) begin
            if (m_area[l] > 0) begin
                e = '{done: 0, label: 16'(l), xmin: 11'(m_xmin[l]), xmax: 11'(m_xmax[l]),
                      ymin: 10'(m_ymin[l]), ymax: 10'(m_ymax[l]), area: 16'(m_area[l]),
                      ovf: 0, drop: 0};
                q.push_back(e);
            end
        end
        e = '{done: 1, label: 0, xmin: 0, xmax: 0, ymin: 0, ymax: 0, area: 0,
              ovf: m_ovf, drop: (junk > 0)};
        q.push_back(e);
        for (int j = 0; j < junk; j++) begin
            p = '{v: 1'b1, l: 16'(1 + $urandom % MAXT), x: 11'($urandom % HRES), y: 10'($urandom % VRES)};
            drive(p);
        end
        p = '{v: 1'b0, l: 16'd0, x: 11'd0, y: 10'd0};
        drive(p);
        pxq.delete();
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(posedge clk_in);
            #1;
            if (frame_done_out) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_done: got no frame_done_out expected within %0d cycles", bound);
        end
    endtask

    task automatic wait_valid(input int bound);
        bit seen = 0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(posedge clk_in);
            #1;
            if (blob_valid_out) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_valid: got no blob_valid_out expected within %0d cycles", bound);
        end
    endtask

    task automatic add_px(input int l, input int x, input int y);
        px_t p;
        p = '{v: 1'b1, l: 16'(l), x: 11'(x), y: 10'(y)};
        pxq.push_back(p);
    endtask

    initial begin
        px_t p;
        int  n_done;
        bit  seen;
        rst_n_in = 1'b0;
        valid_in = 1'b0; label_in = '0; hcount_in = '0; vcount_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", blob_valid_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_drop", dropped_out, 0);
        chk("rst_label", blob_label_out, 0);
        chk("rst_area", blob_area_out, 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // 3x2 blob of label 1, ready high; first-record latency
        for (int y = 5; y <= 6; y++)
            for (int x = 10; x <= 12; x++) add_px(1, x, y);
        run_frame(16'd0, 0);
        chk("lat_scan", blob_valid_out, 0);
        @(posedge clk_in);
        #1;
        chk("lat_emit", blob_valid_out, 1);
        wait_done(200);

        // Corner single pixels, labels 2 and 5 (label 5 is the EOF pixel)
        add_px(2, 0, 0);
        run_frame(16'd5, 0);
        wait_done(200);

        // Empty frame latency
        run_frame(16'd0, 0);
        n_done = 0;
        seen   = 0;
        for (int n = 2; n < 60 && !seen; n++) begin
            @(posedge clk_in);
            #1;
            if (frame_done_out) begin seen = 1; n_done = n; end
        end
        chk("empty_latency", n_done, MAXT + 2);

        // Ready held low for 20 cycles during EMIT
        force_low = 1;
        add_px(7, 100, 50); add_px(7, 101, 50); add_px(9, 30, 40);
        run_frame(16'd0, 0);
        wait_valid(100);
        repeat (20) @(posedge clk_in);
        force_low = 0;
        wait_done(200);

        // Out-of-range label with a tracked label
        add_px(40, 5, 5); add_px(3, 60, 70); add_px(40, 6, 6); add_px(3, 61, 72);
        run_frame(16'd0, 0);
        wait_done(200);

        // Pixels during SCAN/EMIT are dropped and flagged; next frame is clean
        add_px(4, 200, 100); add_px(4, 201, 101);
        run_frame(16'd0, 3);
        wait_done(200);
        add_px(4, 150, 90);
        run_frame(16'd0, 0);
        wait_done(200);

        // Asynchronous reset mid-EMIT
        force_low = 1;
        add_px(6, 20, 20); add_px(6, 21, 22);
        run_frame(16'd0, 0);
        wait_valid(100);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_valid", blob_valid_out, 0);
        chk("async_rst_label", blob_label_out, 0);
        q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in  = 1'b1;
        force_low = 0;
        add_px(6, 50, 50);
        run_frame(16'd0, 0);
        wait_done(200);

        // Randomized frames with random backpressure
        ready_rand = 1;
        for (int f = 0; f < 8; f++) begin
            int n;
            n = 20 + $urandom % 60;
            for (int k = 0; k < n; k++) begin
                int r;
                p.v = (($urandom % 4) != 0);
                p.x = 11'($urandom % HRES);
                p.y = 10'($urandom % VRES);
                r = $urandom % 10;
                if (r == 0) p.l = 16'(17 + $urandom % 30);
                else if (r == 1) begin
                    p.l = 16'(1 + $urandom % MAXT);
                    if ($urandom % 2 == 0) p.x = 11'(HRES + $urandom % 100);
                    else                   p.y = 10'(VRES + $urandom % 50);
                end else p.l = 16'($urandom % (MAXT + 1));
                if (!p.v && r == 2) begin
                    p.x = 11'(HRES - 1); p.y = 10'(VRES - 1);
                end
                if (p.v && p.x == 11'(HRES - 1) && p.y == 10'(VRES - 1)) p.x = 11'(HRES - 2);
                pxq.push_back(p);
            end
            run_frame(16'($urandom % (MAXT + 1)), ($urandom % 2 == 1) ? 1 + $urandom % 3 : 0);
            wait_done(3000);
        end

        repeat (3) @(posedge clk_in);
        chk("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
